// File: rtl/sipo_pkg.sv
// Shared types and defaults for the LSB-first serial link receiver.
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/sipo_hold_reg.sv
// One-entry valid/ready holding register; flags a word that arrives while full and not draining.
module sipo_hold_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             drop
);

    logic can_load;

    assign can_load = !out_valid || out_ready;
    assign drop     = in_valid && !can_load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (in_valid && can_load) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel receiver: assembles LSB-first bits into words and hands them
// to a one-entry holding register, tracking overrun and framing errors.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    input  logic             out_ready,
    input  logic             err_clr,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    // Only the upper WIDTH-1 bits of the shifter are kept; bit 0 would be shifted
    // out before it could ever contribute to a word.
    logic [WIDTH-2:0] shift_reg, shift_nxt;
    logic [CNT_W-1:0] bit_cnt, cnt_nxt;
    logic [WIDTH-1:0] word;
    logic             word_done;
    logic             ferr_evt;
    logic             drop;

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        cnt_nxt   = bit_cnt;
        word_done = 1'b0;
        ferr_evt  = 1'b0;
        word      = {serial_in, shift_reg};

        if (bit_valid) begin
            if (frame_start) begin
                // Any frame_start restarts at bit 0; only a partial word is an error.
                ferr_evt             = (state == SHIFT) && (bit_cnt != '0);
                shift_nxt            = '0;
                shift_nxt[WIDTH-2]   = serial_in;
                cnt_nxt              = CNT_ONE;
                state_nxt            = SHIFT;
            end else if (state == SHIFT) begin
                shift_nxt = word[WIDTH-1:1];
                if (bit_cnt == CNT_LAST) begin
                    cnt_nxt   = '0;
                    word_done = 1'b1;
                end else begin
                    cnt_nxt = bit_cnt + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= cnt_nxt;
        end
    end

    // Sticky flags: a new event on the clearing edge wins over err_clr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= (overrun && !err_clr) || drop;
            frame_err <= (frame_err && !err_clr) || ferr_evt;
        end
    end

    assign busy = (state == SHIFT) && (bit_cnt != '0);

    sipo_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (word_done),
        .in_data  (word),
        .out_ready(out_ready),
        .out_data (parallel_out),
        .out_valid(out_valid),
        .drop     (drop)
    );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer at WIDTH=4 with hand-computed expectations.
module tb_sipo_deserializer;

    localparam int W = 4;

    logic         clk;
    logic         reset_n;
    logic         serial_in;
    logic         bit_valid;
    logic         frame_start;
    logic         out_ready;
    logic         err_clr;
    logic [W-1:0] parallel_out;
    logic         out_valid;
    logic         busy;
    logic         overrun;
    logic         frame_err;

    int n_checks = 0;
    int n_errors = 0;

    sipo_deserializer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .serial_in   (serial_in),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .out_ready   (out_ready),
        .err_clr     (err_clr),
        .parallel_out(parallel_out),
        .out_valid   (out_valid),
        .busy        (busy),
        .overrun     (overrun),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic fs, input logic b);
        bit_valid   = 1'b1;
        frame_start = fs;
        serial_in   = b;
        tick();
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        serial_in   = 1'b0;
    endtask

    task automatic send_word(input logic fs, input logic [3:0] w);
        for (int i = 0; i < W; i++) send(fs && (i == 0), w[i]);
    endtask

    initial begin
        reset_n     = 1'b0;
        serial_in   = 1'b0;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        out_ready   = 1'b0;
        err_clr     = 1'b0;
        repeat (2) tick();

        check_eq("rst parallel_out", parallel_out, 4'h0);
        check_eq("rst out_valid", 4'(out_valid), 4'h0);
        check_eq("rst busy", 4'(busy), 4'h0);
        check_eq("rst overrun", 4'(overrun), 4'h0);
        check_eq("rst frame_err", 4'(frame_err), 4'h0);
        reset_n = 1'b1;
        tick();

        // Basic word 1011 sent LSB first: 1,1,0,1
        send(1'b1, 1'b1);
        send(1'b0, 1'b1);
        check_eq("basic busy mid", 4'(busy), 4'h1);
        send(1'b0, 1'b0);
        check_eq("basic no early valid", 4'(out_valid), 4'h0);
        send(1'b0, 1'b1);
        check_eq("basic valid", 4'(out_valid), 4'h1);
        check_eq("basic data", parallel_out, 4'b1011);
        check_eq("basic busy end", 4'(busy), 4'h0);
        out_ready = 1'b1;
        tick();
        check_eq("basic drain", 4'(out_valid), 4'h0);

        // Streaming 0110 then 1001 with a single frame_start
        send(1'b1, 1'b0);
        send(1'b0, 1'b1);
        send(1'b0, 1'b1);
        send(1'b0, 1'b0);
        check_eq("stream w0 valid", 4'(out_valid), 4'h1);
        check_eq("stream w0 data", parallel_out, 4'b0110);
        send(1'b0, 1'b1);
        check_eq("stream w0 one cycle", 4'(out_valid), 4'h0);
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        send(1'b0, 1'b1);
        check_eq("stream w1 valid", 4'(out_valid), 4'h1);
        check_eq("stream w1 data", parallel_out, 4'b1001);
        tick();
        check_eq("stream w1 one cycle", 4'(out_valid), 4'h0);
        check_eq("stream overrun", 4'(overrun), 4'h0);

        // Overrun: second word dropped while the first is held
        out_ready = 1'b0;
        send_word(1'b1, 4'b0110);
        send_word(1'b0, 4'b1001);
        check_eq("ovr valid", 4'(out_valid), 4'h1);
        check_eq("ovr data kept", parallel_out, 4'b0110);
        check_eq("ovr flag", 4'(overrun), 4'h1);
        check_eq("ovr no frame_err", 4'(frame_err), 4'h0);
        out_ready = 1'b1;
        tick();
        check_eq("ovr accepted", 4'(out_valid), 4'h0);
        check_eq("ovr sticky", 4'(overrun), 4'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("ovr cleared", 4'(overrun), 4'h0);

        // Simultaneous completion and drain
        out_ready = 1'b0;
        send_word(1'b1, 4'b0110);
        send(1'b0, 1'b1);
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        check_eq("simul held", parallel_out, 4'b0110);
        out_ready = 1'b1;
        send(1'b0, 1'b1);
        check_eq("simul valid", 4'(out_valid), 4'h1);
        check_eq("simul data", parallel_out, 4'b1001);
        check_eq("simul overrun", 4'(overrun), 4'h0);
        tick();
        check_eq("simul drain", 4'(out_valid), 4'h0);

        // Framing: frame_start after two bits, then 1,1,1,1
        send(1'b1, 1'b0);
        send(1'b0, 1'b1);
        check_eq("frm no err yet", 4'(frame_err), 4'h0);
        send(1'b1, 1'b1);
        send(1'b0, 1'b1);
        send(1'b0, 1'b1);
        check_eq("frm partial dropped", 4'(out_valid), 4'h0);
        send(1'b0, 1'b1);
        check_eq("frm err", 4'(frame_err), 4'h1);
        check_eq("frm valid", 4'(out_valid), 4'h1);
        check_eq("frm data", parallel_out, 4'b1111);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("frm cleared", 4'(frame_err), 4'h0);

        // frame_start with WIDTH-1 bits held aborts the word
        send(1'b1, 1'b1);
        send(1'b0, 1'b1);
        send(1'b0, 1'b1);
        send(1'b1, 1'b0);
        check_eq("abort err", 4'(frame_err), 4'h1);
        check_eq("abort no word", 4'(out_valid), 4'h0);
        check_eq("abort busy", 4'(busy), 4'h1);

        // New error on the clearing edge keeps the flag set
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("clr only", 4'(frame_err), 4'h0);
        err_clr = 1'b1;
        send(1'b1, 1'b0);
        err_clr = 1'b0;
        check_eq("clr vs event", 4'(frame_err), 4'h1);

        // Async reset with a held word and bit_cnt=2
        out_ready = 1'b0;
        send_word(1'b1, 4'b0110);
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        check_eq("pre-rst valid", 4'(out_valid), 4'h1);
        check_eq("pre-rst busy", 4'(busy), 4'h1);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("arst valid", 4'(out_valid), 4'h0);
        check_eq("arst data", parallel_out, 4'h0);
        check_eq("arst busy", 4'(busy), 4'h0);
        check_eq("arst frame_err", 4'(frame_err), 4'h0);
        #1;
        reset_n = 1'b1;
        tick();

        // Stray bits without frame_start are ignored
        send_word(1'b0, 4'b1111);
        check_eq("stray no word", 4'(out_valid), 4'h0);
        check_eq("stray not busy", 4'(busy), 4'h0);
        send_word(1'b1, 4'b0011);
        check_eq("post-rst valid", 4'(out_valid), 4'h1);
        check_eq("post-rst data", parallel_out, 4'b0011);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-to-parallel receiver. It is the receive end of the team's LSB-first serial shift link.
- Accumulates WIDTH bits sampled on strobed clock edges into a word and presents the word on a valid/ready output with one holding stage.
- Sits between a serial line source and a parallel consumer; detects overrun and framing errors.

Parameters:
- WIDTH, 4, bits per word; must be at least 2.
- CNT_W, $clog2(WIDTH), width of the bit counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- serial_in  input  1  serial data bit, LSB of the word first.
- bit_valid  input  1  serial_in is sampled on this edge only when high.
- frame_start  input  1  qualified by bit_valid; marks the current bit as bit 0 of a new word.
- out_ready  input  1  consumer accepts the word.
- parallel_out  output  WIDTH  assembled word; stable while out_valid=1.
- out_valid  output  1  holding register full.
- busy  output  1  state=SHIFT with a partial word (bit_cnt≠0).
- overrun  output  1  sticky: a completed word was dropped.
- frame_err  output  1  sticky: frame_start arrived mid-word.
- err_clr  input  1  synchronous clear of overrun and frame_err.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, shift_reg=0, bit_cnt=0, parallel_out=0, out_valid=0, busy=0, overrun=0, frame_err=0.
- FSM, two states:
  - IDLE: bit_valid without frame_start is ignored. bit_valid&frame_start loads serial_in into the MSB of shift_reg, sets bit_cnt=1, and goes to SHIFT.
  - SHIFT: each bit_valid performs shift_reg <= {serial_in, shift_reg[WIDTH-1:1]} and bit_cnt += 1.
- Word completion: on an edge with bit_valid and bit_cnt=WIDTH-1 (no frame_start), the word {serial_in, shift_reg[WIDTH-1:1]} is complete. bit_cnt wraps to 0 and the state stays SHIFT, so back-to-back words need no new frame_start.
- Completion latency: out_valid rises on the same edge that samples the last bit and is visible the cycle after. There is no extra pipeline stage.
- Output handshake: a transfer occurs on an edge with out_valid&out_ready. After the transfer, out_valid clears unless a word completes on that same edge.
- Holding register:
  - Empty, or draining on this edge: the completed word loads and out_valid=1.
  - Full and not draining: the completed word is discarded, parallel_out is unchanged, and overrun is set.
  - Completion and drain on the same edge: the new word loads, out_valid stays 1, and no overrun is flagged.
- frame_start in SHIFT with bit_cnt≠0: the partial word is discarded and frame_err is set. The current bit becomes bit 0 (shift_reg MSB=serial_in, bit_cnt=1).
- frame_start in SHIFT with bit_cnt=0: a legal resync; no error is flagged.
- frame_start when WIDTH-1 bits are held: this is treated as mid-word. The word is aborted and not completed.
- frame_start without bit_valid: ignored.
- err_clr: clears both sticky flags. If a new error event occurs on the same edge as err_clr, the flag ends set.
- parallel_out is registered, with no combinational path from serial_in.
- Reset asserted mid-word or with out_valid=1: everything returns to reset values immediately, and the pending word is lost.
- bit_valid low: no state change except the output handshake and err_clr.

Decomposition:
- Shared package sipo_pkg holds:
  - the state enum {IDLE, SHIFT};
  - the constant DEF_WIDTH=4.
- Optional sub-module sipo_hold_reg: a one-entry valid/ready holding register that reports overrun. The shift/count FSM stays in the top level.

Test Plan:
- Basic word: reset, then bit_valid with frame_start on bit 1, then bits 1,0,1 (LSB first) → the cycle after the 4th bit, out_valid=1 and parallel_out=4'b1011. With out_ready=1, out_valid drops the next cycle.
- Streaming: frame_start once, then 8 consecutive bits encoding 4'b0110 followed by 4'b1001, out_ready held at 1 → two words, each valid for exactly one cycle; overrun=0.
- Overrun: two words as above with out_ready=0 → parallel_out stays 4'b0110 and overrun=1. Then out_ready=1 → 4'b0110 is accepted. Then err_clr → overrun=0.
- Simultaneous: the second word completes on the same edge as the first is accepted → out_valid stays 1, parallel_out=4'b1001, overrun=0.
- Framing: frame_start, 2 bits, then frame_start with bits 1,1,1,1 → frame_err=1, the partial is dropped, parallel_out=4'b1111.
- Async reset: assert reset_n=0 mid-clock with out_valid=1 and bit_cnt=2 → all outputs are 0 before the next edge. Stray bits without frame_start after reset → no word produced.
